// File: rtl/dual_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler_if
// Description : Bundle between the instruction buffer and the dual-issue
//               scheduler: two oldest slots in, launch flags and unit routing
//               out.
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_issue_scheduler_if;
  logic       stop;
  logic       flush;

  logic       s1_valid;
  logic [1:0] s1_class;
  logic       s1_we;
  logic [4:0] s1_rd;
  logic [4:0] s1_rs1;
  logic [4:0] s1_rs2;
  logic       s1_use1;
  logic       s1_use2;

  logic       s2_valid;
  logic [1:0] s2_class;
  logic       s2_we;
  logic [4:0] s2_rd;
  logic [4:0] s2_rs1;
  logic [4:0] s2_rs2;
  logic       s2_use1;
  logic       s2_use2;

  logic       issue1;
  logic       issue2;
  logic       u0_valid;
  logic       u0_sel;
  logic       u0_num;
  logic       u1_valid;
  logic       u1_sel;
  logic       u1_num;

  // Instruction-buffer side
  modport master (
    output stop, flush,
    output s1_valid, s1_class, s1_we, s1_rd, s1_rs1, s1_rs2, s1_use1, s1_use2,
    output s2_valid, s2_class, s2_we, s2_rd, s2_rs1, s2_rs2, s2_use1, s2_use2,
    input  issue1, issue2, u0_valid, u0_sel, u0_num, u1_valid, u1_sel, u1_num
  );

  // Scheduler side
  modport slave (
    input  stop, flush,
    input  s1_valid, s1_class, s1_we, s1_rd, s1_rs1, s1_rs2, s1_use1, s1_use2,
    input  s2_valid, s2_class, s2_we, s2_rd, s2_rs1, s2_rs2, s2_use1, s2_use2,
    output issue1, issue2, u0_valid, u0_sel, u0_num, u1_valid, u1_sel, u1_num
  );
endinterface
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Zero-latency dual-issue controller. Picks which of the two
//               oldest instructions launch, routes them to unit 0 (ALU+branch)
//               or unit 1 (ALU+memory), holds RAW hazards with a per-register
//               latency scoreboard and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
  parameter int LAT_ALU = 1,
  parameter int LAT_MEM = 2,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,       // asynchronous, active-low
  dual_issue_scheduler_if.slave  bus,
  output logic [PERF_W-1:0]      stall_cnt
);

  localparam logic [1:0]       c_cls_br  = 2'b01;
  localparam logic [1:0]       c_cls_mem = 2'b10;
  localparam logic [CNT_W-1:0] c_ld_alu  = CNT_W'(LAT_ALU - 1);
  localparam logic [CNT_W-1:0] c_ld_mem  = CNT_W'(LAT_MEM - 1);

  logic [CNT_W-1:0]  w_cnt [32];
  logic [PERF_W-1:0] r_stall_cnt;

  logic w_s1_br, w_s1_mem, w_s1_alu;
  logic w_s2_br, w_s2_mem, w_s2_alu;
  logic w_s1_ready, w_s2_ready;
  logic w_raw, w_waw;
  logic w_s1_on_u1, w_s2_on_u1, w_s2_unit_ok;
  logic w_issue1, w_issue2;

  // x0 never carries a pending write
  assign w_cnt[0] = '0;

  assign w_s1_br  = (bus.s1_class == c_cls_br);
  assign w_s1_mem = (bus.s1_class == c_cls_mem);
  assign w_s1_alu = !w_s1_br && !w_s1_mem;
  assign w_s2_br  = (bus.s2_class == c_cls_br);
  assign w_s2_mem = (bus.s2_class == c_cls_mem);
  assign w_s2_alu = !w_s2_br && !w_s2_mem;

  // A source is ready when unused, x0, or its register has no pending write
  assign w_s1_ready = (!bus.s1_use1 || (w_cnt[bus.s1_rs1] == '0)) &&
                      (!bus.s1_use2 || (w_cnt[bus.s1_rs2] == '0));
  assign w_s2_ready = (!bus.s2_use1 || (w_cnt[bus.s2_rs1] == '0)) &&
                      (!bus.s2_use2 || (w_cnt[bus.s2_rs2] == '0));

  // Same-cycle hazards between the pair
  assign w_raw = bus.s1_we && (bus.s1_rd != 5'd0) &&
                 ((bus.s2_use1 && (bus.s2_rs1 == bus.s1_rd)) ||
                  (bus.s2_use2 && (bus.s2_rs2 == bus.s1_rd)));
  assign w_waw = bus.s1_we && bus.s2_we && (bus.s1_rd != 5'd0) &&
                 (bus.s1_rd == bus.s2_rd);

  // Slot1 ALU yields u0 when the younger slot holds a branch
  assign w_s1_on_u1 = w_s1_mem || (w_s1_alu && bus.s2_valid && w_s2_br);

  assign w_s2_unit_ok = w_s2_mem ? !w_s1_on_u1 :
                        w_s2_br  ?  w_s1_on_u1 : 1'b1;
  assign w_s2_on_u1   = w_s2_mem || (w_s2_alu && !w_s1_on_u1);

  assign w_issue1 = bus.s1_valid && !bus.stop && !bus.flush && w_s1_ready;
  assign w_issue2 = w_issue1 && bus.s2_valid && w_s2_ready && !w_s1_br &&
                    !w_raw && !w_waw && w_s2_unit_ok;

  // Outputs are held low for the whole time reset is asserted
  assign bus.issue1   = rst && w_issue1;
  assign bus.issue2   = rst && w_issue2;
  assign bus.u0_valid = rst && ((w_issue1 && !w_s1_on_u1) || (w_issue2 && !w_s2_on_u1));
  assign bus.u0_sel   = rst && w_issue2 && !w_s2_on_u1;
  assign bus.u0_num   = bus.u0_sel;
  assign bus.u1_valid = rst && ((w_issue1 && w_s1_on_u1) || (w_issue2 && w_s2_on_u1));
  assign bus.u1_sel   = rst && w_issue2 && w_s2_on_u1;
  assign bus.u1_num   = bus.u1_sel;

  for (genvar i = 1; i < 32; i++) begin : g_sb
    localparam logic [4:0] c_reg = 5'(i);
    logic             w_hit1;
    logic             w_hit2;
    logic [CNT_W-1:0] r_cnt;

    assign w_hit1   = w_issue1 && bus.s1_we && (bus.s1_rd == c_reg);
    assign w_hit2   = w_issue2 && bus.s2_we && (bus.s2_rd == c_reg);
    assign w_cnt[i] = r_cnt;

    // Load latency on an issuing write, otherwise count down to zero
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_hit2) begin
        r_cnt <= w_s2_mem ? c_ld_mem : c_ld_alu;
      end else if (w_hit1) begin
        r_cnt <= w_s1_mem ? c_ld_mem : c_ld_alu;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Count cycles where the oldest instruction is present but held back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (bus.s1_valid && !w_issue1) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Self-checking bench for dual_issue_scheduler: table of
//               single-cycle pairings plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

  typedef struct packed {
    logic       valid;
    logic [1:0] cls;
    logic       we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } slot_t;

  // exp = {issue1, issue2, u0_valid, u0_sel, u0_num, u1_valid, u1_sel, u1_num}
  typedef struct {
    slot_t      s1;
    slot_t      s2;
    logic       stop;
    logic       flush;
    logic [7:0] exp;
  } vec_t;

  localparam logic [1:0] ALU = 2'b00, BR = 2'b01, MEM = 2'b10, ALT = 2'b11;

  logic clk;
  logic rst;
  logic [31:0] stall_cnt;

  dual_issue_scheduler_if bus ();

  dual_issue_scheduler #(
    .LAT_ALU(1), .LAT_MEM(2), .CNT_W(2), .PERF_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [7:0]  exp_q [$];
  logic        cur_s1v;
  logic [31:0] m_stall;

  function automatic slot_t mk(logic v, logic [1:0] c, logic we, int rd,
                               int rs1, int rs2, logic u1, logic u2);
    slot_t s;
    s.valid = v;  s.cls = c;  s.we = we;
    s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.use1 = u1;  s.use2 = u2;
    return s;
  endfunction

  function automatic slot_t nop();
    return mk(1'b0, ALU, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endfunction

  task automatic drive(slot_t a, slot_t b, logic st, logic fl, logic [7:0] exp);
    @(negedge clk);
    bus.stop = st;  bus.flush = fl;
    bus.s1_valid = a.valid; bus.s1_class = a.cls; bus.s1_we = a.we;
    bus.s1_rd = a.rd; bus.s1_rs1 = a.rs1; bus.s1_rs2 = a.rs2;
    bus.s1_use1 = a.use1; bus.s1_use2 = a.use2;
    bus.s2_valid = b.valid; bus.s2_class = b.cls; bus.s2_we = b.we;
    bus.s2_rd = b.rd; bus.s2_rs1 = b.rs1; bus.s2_rs2 = b.rs2;
    bus.s2_use1 = b.use1; bus.s2_use2 = b.use2;
    cur_s1v = a.valid;
    exp_q.push_back(exp);
  endtask

  task automatic check(string tag);
    logic [7:0] exp, act;
    #2;
    exp = exp_q.pop_front();
    act = {bus.issue1, bus.issue2, bus.u0_valid, bus.u0_sel, bus.u0_num,
           bus.u1_valid, bus.u1_sel, bus.u1_num};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s outputs: got %b expected %b", tag, act, exp);
    end
    n_vec++;
    if (stall_cnt !== m_stall) begin
      n_err++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, m_stall);
    end
    // The coming clock edge counts this cycle if the oldest slot stalls
    if (rst && cur_s1v && !exp[7]) m_stall++;
  endtask

  task automatic step(slot_t a, slot_t b, logic st, logic fl, logic [7:0] exp, string tag);
    drive(a, b, st, fl, exp);
    check(tag);
  endtask

  vec_t vt [$];

  initial begin
    n_vec = 0; n_err = 0; m_stall = '0; cur_s1v = 1'b0;
    rst = 1'b0;

    // Independent pairings, empty scoreboard
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'b11100111});
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), mk(1,BR ,0,0,4,5,1,1), 0, 0, 8'b11111100});
    vt.push_back('{mk(1,MEM,1,3,2,0,1,0), mk(1,MEM,1,4,2,0,1,0), 0, 0, 8'b10000100});
    vt.push_back('{mk(1,BR ,0,0,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'b10100000});
    vt.push_back('{mk(1,MEM,1,3,2,0,1,0), mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'b11111100});
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), mk(1,MEM,1,4,5,0,1,0), 0, 0, 8'b11100111});
    vt.push_back('{mk(1,ALU,1,7,2,3,1,1), mk(1,ALU,1,8,7,2,1,1), 0, 0, 8'b10100000});
    vt.push_back('{mk(1,ALU,1,0,2,3,1,1), mk(1,ALU,1,8,0,2,1,1), 0, 0, 8'b11100111});
    vt.push_back('{mk(1,ALU,1,7,2,3,1,1), mk(1,ALU,1,8,2,7,1,0), 0, 0, 8'b11100111});
    vt.push_back('{mk(1,ALU,1,9,2,3,1,1), mk(1,ALU,1,9,4,5,1,1), 0, 0, 8'b10100000});
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 1, 0, 8'b00000000});
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 0, 1, 8'b00000000});
    vt.push_back('{nop(),                 mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'b00000000});
    vt.push_back('{mk(1,ALU,1,1,2,3,1,1), nop(),                 0, 0, 8'b10100000});
    vt.push_back('{mk(1,MEM,0,0,2,3,1,1), mk(1,BR ,0,0,4,5,1,1), 0, 0, 8'b11111100});
    vt.push_back('{mk(1,BR ,0,0,2,3,1,1), mk(1,BR ,0,0,4,5,1,1), 0, 0, 8'b10100000});
    vt.push_back('{mk(1,ALT,1,1,2,3,1,1), mk(1,ALT,1,4,5,6,1,1), 0, 0, 8'b11100111});

    // Reset state: outputs held low even with a ready instruction present
    step(mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'h00, "reset_a");
    step(mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,5,6,1,1), 0, 0, 8'h00, "reset_b");
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s1, vt[i].s2, vt[i].stop, vt[i].flush, vt[i].exp, $sformatf("vec%0d", i));
      step(nop(), nop(), 0, 0, 8'h00, $sformatf("idle%0d", i));
    end

    // Load-use: blocked one cycle, then issues
    step(mk(1,MEM,1,5,2,0,1,0), nop(), 0, 0, 8'b10000100, "lw_x5");
    step(mk(1,ALU,1,6,5,1,1,1), nop(), 0, 0, 8'b00000000, "lu_block");
    step(mk(1,ALU,1,6,5,1,1,1), nop(), 0, 0, 8'b10100000, "lu_issue");
    step(nop(), nop(), 0, 0, 8'h00, "lu_idle");

    // Same-cycle RAW, then the dependant issues next cycle on u0
    step(mk(1,ALU,1,7,2,3,1,1), mk(1,ALU,1,8,7,2,1,1), 0, 0, 8'b10100000, "raw_a");
    step(mk(1,ALU,1,8,7,2,1,1), nop(), 0, 0, 8'b10100000, "raw_b");

    // Flush: no issue, scoreboard still drains
    step(mk(1,MEM,1,5,2,0,1,0), nop(), 0, 0, 8'b10000100, "fl_lw");
    step(mk(1,ALU,1,1,2,3,1,1), mk(1,ALU,1,4,6,7,1,1), 0, 1, 8'b00000000, "fl_flush");
    step(mk(1,ALU,1,6,5,5,1,1), nop(), 0, 0, 8'b10100000, "fl_after");

    // Writes to x0 never block
    step(mk(1,MEM,1,0,2,0,1,0), nop(), 0, 0, 8'b10000100, "x0_lw");
    step(mk(1,ALU,1,6,0,0,1,1), nop(), 0, 0, 8'b10100000, "x0_read");

    // Asynchronous reset mid-operation
    step(mk(1,MEM,1,5,2,0,1,0), nop(), 0, 0, 8'b10000100, "ar_lw");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    m_stall = '0;
    n_vec++;
    if (stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL ar_stall: got %0d expected 0", stall_cnt);
    end
    n_vec++;
    if ({bus.issue1, bus.u1_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL ar_outputs: got %b expected 00", {bus.issue1, bus.u1_valid});
    end
    #1 rst = 1'b1;
    step(mk(1,ALU,1,6,5,1,1,1), nop(), 0, 0, 8'b10100000, "ar_reader");
    step(nop(), nop(), 0, 0, 8'h00, "end_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
